rc_add_sub_64: RTL and testbench



---
 rtl/rc_add_sub_64.sv | 51 +++++
 tb/tb_rc_add_sub_64.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rc_add_sub_64.sv
// 64-bit ripple-carry adder/subtractor with registered sum and carry-out.
// Subtraction is A + ~B + 1; the chain is cascaded as two 32-bit ripple stages.
module rc_add_sub_64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        SnA,
  output logic [63:0] Y,
  output logic        CO
);

  logic [63:0] bEff;
  logic [31:0] sumLo;
  logic [31:0] sumHi;
  logic        carryMid;
  logic        carryOut;

  // One 32-bit ripple stage; returns {carryOut, sum}.
  function automatic logic [32:0] ripple32(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        cIn);
    logic [31:0] s;
    logic        c;
    c = cIn;
    for (int i = 0; i < 32; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  assign bEff = B ^ {64{SnA}};

  // Carry out of bit 31 feeds bit 32, keeping the cascade identical to a flat chain.
  always_comb begin
    {carryMid, sumLo} = ripple32(A[31:0], bEff[31:0], SnA);
    {carryOut, sumHi} = ripple32(A[63:32], bEff[63:32], carryMid);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Y  <= 64'h0;
      CO <= 1'b0;
    end else begin
      Y  <= {sumHi, sumLo};
      CO <= carryOut;
    end
  end

endmodule

// File: tb/tb_rc_add_sub_64.sv
// Self-checking bench for rc_add_sub_64: directed vector table, reset sequences
// and random operations, all checked through a one-cycle scoreboard queue.
module tb_rc_add_sub_64;

  logic        CLK;
  logic        RST;
  logic [63:0] A;
  logic [63:0] B;
  logic        SnA;
  logic [63:0] Y;
  logic        CO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        snA;
    logic [63:0] expY;
    logic        expCo;
  } vec_t;

  typedef struct {
    logic [63:0] y;
    logic        co;
    int          tag;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[$];

  rc_add_sub_64 dut (
    .CLK(CLK),
    .RST(RST),
    .A  (A),
    .B  (B),
    .SnA(SnA),
    .Y  (Y),
    .CO (CO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [64:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                           input logic s);
    logic [64:0] bOp;
    bOp = s ? ({1'b0, ~b} + 65'd1) : {1'b0, b};
    return {1'b0, a} + bOp;
  endfunction

  // Drive one operation at the falling edge and queue what the next rising edge must produce.
  task automatic applyOp(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic [63:0] expY, input logic expCo, input int tag);
    exp_t e;
    @(negedge CLK);
    A   = a;
    B   = b;
    SnA = s;
    e.y = expY;
    e.co = expCo;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  // Scoreboard monitor: compare one entry per rising edge, 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RST && expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (Y !== e.y || CO !== e.co) begin
          errors++;
          $display("FAIL op%0d: got Y=%h CO=%b, expected Y=%h CO=%b",
                   e.tag, Y, CO, e.y, e.co);
        end
      end
    end
  end

  task automatic checkZero(input int tag);
    checks++;
    if (Y !== 64'h0 || CO !== 1'b0) begin
      errors++;
      $display("FAIL reset%0d: got Y=%h CO=%b, expected Y=0 CO=0", tag, Y, CO);
    end
  endtask

  initial begin
    logic [64:0] r;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;

    vecs.push_back('{64'h0, 64'h0, 1'b0, 64'h0, 1'b0});
    vecs.push_back('{64'h1, 64'h1, 1'b0, 64'h2, 1'b0});
    vecs.push_back('{64'h2, 64'h2, 1'b0, 64'h4, 1'b0});
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1});
    vecs.push_back('{64'h00000000FFFFFFFF, 64'h1, 1'b0, 64'h0000000100000000, 1'b0});
    vecs.push_back('{64'h1, 64'h1, 1'b1, 64'h0, 1'b1});
    vecs.push_back('{64'h7, 64'h3, 1'b1, 64'h4, 1'b1});
    vecs.push_back('{64'hFF00000000000000, 64'hEEEEEEEEEEEEEEEE, 1'b1,
                     64'h1011111111111112, 1'b1});
    vecs.push_back('{64'h0, 64'h1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0});
    vecs.push_back('{64'h5, 64'h0, 1'b1, 64'h5, 1'b1});
    vecs.push_back('{64'h0000000100000000, 64'h1, 1'b1, 64'h00000000FFFFFFFF, 1'b1});

    A   = '1;
    B   = '1;
    SnA = 1'b0;
    RST = 1'b0;
    #1;
    checkZero(0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      #2;
      checkZero(i);
    end

    // Release reset: first edge captures all-ones + all-ones.
    @(negedge CLK);
    RST = 1'b1;
    begin
      exp_t e;
      e.y = 64'hFFFFFFFFFFFFFFFE;
      e.co = 1'b1;
      e.tag = 1000;
      expQ.push_back(e);
    end

    // Directed table, applied back-to-back on consecutive cycles.
    for (int i = 0; i < vecs.size(); i++)
      applyOp(vecs[i].a, vecs[i].b, vecs[i].snA, vecs[i].expY, vecs[i].expCo, i);

    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) rb = ra;
      if (i % 77 == 0) ra = 64'h0;
      r = refModel(ra, rb, rs);
      applyOp(ra, rb, rs, r[63:0], r[64], 2000 + i);
      if (i == 5000) begin
        // Async pulse between edges: outputs clear at once, next edge resumes.
        #1;
        RST = 1'b0;
        #1;
        checkZero(100);
        #1;
        RST = 1'b1;
      end
    end

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
